// File: rtl/reg_file.sv
// Architectural register file with rename tags. Accepts ROB commits and issue-time renames,
// and answers two source-operand queries with a same-cycle commit bypass.
module reg_file #(
   parameter int unsigned ROB_LOG = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               flush,
   input  logic               commit_en,
   input  logic [4:0]         commit_index,
   input  logic [ROB_LOG-1:0] commit_rob_id,
   input  logic [31:0]        commit_value,
   input  logic               rename_en,
   input  logic [4:0]         rename_index,
   input  logic [ROB_LOG-1:0] rename_rob_id,
   input  logic [4:0]         rs1_index,
   output logic               rs1_busy,
   output logic [ROB_LOG-1:0] rs1_rob_id,
   output logic [31:0]        rs1_value,
   input  logic [4:0]         rs2_index,
   output logic               rs2_busy,
   output logic [ROB_LOG-1:0] rs2_rob_id,
   output logic [31:0]        rs2_value
);

   typedef struct packed {
      logic               busy;
      logic [ROB_LOG-1:0] tag;
      logic [31:0]        value;
   } query_t;

   logic [31:0]        value_q [32];
   logic [ROB_LOG-1:0] tag_q   [32];
   logic [31:0]        busy_q;

   logic commit_ok;
   logic commit_match;
   logic rename_ok;

   // Decode which of this cycle's updates are allowed to touch state.
   always_comb begin
      commit_ok    = rdy && commit_en && (commit_index != 5'd0);
      commit_match = busy_q[commit_index] && (tag_q[commit_index] == commit_rob_id);
      rename_ok    = rdy && rename_en && (rename_index != 5'd0) && !flush;
   end

   // State update: commit value write, then busy clear on tag match, then flush or rename.
   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_q <= '0;
      end else if (rdy) begin
         if (commit_ok) begin
            // A stale tag still writes the value; only the busy clear is tag-qualified.
            value_q[commit_index] <= commit_value;
            if (commit_match) begin
               busy_q[commit_index] <= 1'b0;
            end
         end
         if (flush) begin
            busy_q <= '0;
         end else if (rename_ok) begin
            // Later assignment wins, so a rename overrides a same-index busy clear.
            busy_q[rename_index] <= 1'b1;
            tag_q[rename_index]  <= rename_rob_id;
         end
      end
   end

   // Query with same-cycle commit bypass; renames in this cycle are deliberately invisible.
   function automatic query_t lookup(input logic [4:0] idx);
      query_t r;
      r = '0;
      if (idx != 5'd0) begin
         r.tag = tag_q[idx];
         if (rdy && commit_en && (commit_index == idx) && busy_q[idx]
             && (tag_q[idx] == commit_rob_id)) begin
            r.busy  = 1'b0;
            r.value = commit_value;
         end else begin
            r.busy  = busy_q[idx];
            r.value = value_q[idx];
         end
      end
      return r;
   endfunction

   query_t q1;
   query_t q2;

   // Drive both read ports from the shared lookup.
   always_comb begin
      q1         = lookup(rs1_index);
      q2         = lookup(rs2_index);
      rs1_busy   = q1.busy;
      rs1_rob_id = q1.tag;
      rs1_value  = q1.value;
      rs2_busy   = q2.busy;
      rs2_rob_id = q2.tag;
      rs2_value  = q2.value;
   end

endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file against an array-based model of the register file rules.
module tb_reg_file;

   localparam int unsigned ROB_LOG = 4;

   logic               clk = 1'b0;
   logic               rst, rdy, flush, commit_en, rename_en;
   logic [4:0]         commit_index, rename_index, rs1_index, rs2_index;
   logic [ROB_LOG-1:0] commit_rob_id, rename_rob_id, rs1_rob_id, rs2_rob_id;
   logic [31:0]        commit_value, rs1_value, rs2_value;
   logic               rs1_busy, rs2_busy;

   int total = 0;
   int bad   = 0;

   // Reference state.
   logic [31:0]        m_val  [32];
   logic               m_busy [32];
   logic [ROB_LOG-1:0] m_tag  [32];

   reg_file #(.ROB_LOG(ROB_LOG)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .commit_en(commit_en), .commit_index(commit_index),
      .commit_rob_id(commit_rob_id), .commit_value(commit_value),
      .rename_en(rename_en), .rename_index(rename_index), .rename_rob_id(rename_rob_id),
      .rs1_index(rs1_index), .rs1_busy(rs1_busy), .rs1_rob_id(rs1_rob_id),
      .rs1_value(rs1_value),
      .rs2_index(rs2_index), .rs2_busy(rs2_busy), .rs2_rob_id(rs2_rob_id),
      .rs2_value(rs2_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_val[i]  = '0;
         m_busy[i] = 1'b0;
         m_tag[i]  = '0;
      end
   endtask

   // Expected {busy, tag, value} for a query given the currently driven inputs.
   function automatic logic [36:0] model_query(input logic [4:0] idx);
      if (idx == 5'd0) return '0;
      if (rdy && commit_en && commit_index == idx && m_busy[idx] && m_tag[idx] == commit_rob_id)
         return {1'b0, m_tag[idx], commit_value};
      return {m_busy[idx], m_tag[idx], m_val[idx]};
   endfunction

   task automatic check_ports(input string tag);
      check({tag, "_rs1"}, 64'({rs1_busy, rs1_rob_id, rs1_value}), 64'(model_query(rs1_index)));
      check({tag, "_rs2"}, 64'({rs2_busy, rs2_rob_id, rs2_value}), 64'(model_query(rs2_index)));
   endtask

   task automatic model_clock();
      logic clr;
      if (!rdy) return;
      clr = 1'b0;
      if (commit_en && commit_index != 0) begin
         clr = m_busy[commit_index] && m_tag[commit_index] == commit_rob_id;
         m_val[commit_index] = commit_value;
         if (clr) m_busy[commit_index] = 1'b0;
      end
      if (flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (rename_en && rename_index != 0) begin
         m_busy[rename_index] = 1'b1;
         m_tag[rename_index]  = rename_rob_id;
      end
   endtask

   // One clock: drive at negedge, check queries before the edge, then advance the model.
   task automatic step(input string tag, input logic ce, input logic [4:0] ci,
                       input logic [ROB_LOG-1:0] cid, input logic [31:0] cv,
                       input logic re, input logic [4:0] ri, input logic [ROB_LOG-1:0] rid,
                       input logic fl, input logic [4:0] q1, input logic [4:0] q2);
      commit_en = ce; commit_index = ci; commit_rob_id = cid; commit_value = cv;
      rename_en = re; rename_index = ri; rename_rob_id = rid; flush = fl;
      rs1_index = q1; rs2_index = q2;
      #2;
      check_ports(tag);
      @(posedge clk);
      model_clock();
      @(negedge clk);
      commit_en = 1'b0; rename_en = 1'b0; flush = 1'b0;
   endtask

   // Idle-input query against constant expectations.
   task automatic probe(input string tag, input logic [4:0] idx, input logic eb,
                        input logic [ROB_LOG-1:0] et, input logic [31:0] ev);
      commit_en = 1'b0; rename_en = 1'b0; flush = 1'b0;
      rs1_index = idx;
      #1;
      check({tag, "_busy"}, 64'(rs1_busy), 64'(eb));
      if (eb) check({tag, "_tag"}, 64'(rs1_rob_id), 64'(et));
      check({tag, "_val"}, 64'(rs1_value), 64'(ev));
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; flush = 1'b0;
      commit_en = 1'b0; commit_index = '0; commit_rob_id = '0; commit_value = '0;
      rename_en = 1'b0; rename_index = '0; rename_rob_id = '0;
      rs1_index = '0; rs2_index = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      probe("reset_x5", 5'd5, 1'b0, '0, 32'h0);
      step("commit_x5", 1'b1, 5'd5, 4'd3, 32'hDEADBEEF, 1'b0, 5'd0, 4'd0, 1'b0, 5'd5, 5'd0);
      probe("x5_after", 5'd5, 1'b0, '0, 32'hDEADBEEF);

      step("ren_x7", 1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd7, 4'd2, 1'b0, 5'd7, 5'd0);
      probe("x7_busy", 5'd7, 1'b1, 4'd2, 32'h0);
      step("byp_x7", 1'b1, 5'd7, 4'd2, 32'h11, 1'b0, 5'd0, 4'd0, 1'b0, 5'd7, 5'd7);
      probe("x7_done", 5'd7, 1'b0, '0, 32'h11);

      step("ren_x7a", 1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd7, 4'd2, 1'b0, 5'd7, 5'd0);
      step("ren_x7b", 1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd7, 4'd9, 1'b0, 5'd7, 5'd0);
      step("stale_x7", 1'b1, 5'd7, 4'd2, 32'h22, 1'b0, 5'd0, 4'd0, 1'b0, 5'd7, 5'd0);
      probe("x7_stale", 5'd7, 1'b1, 4'd9, 32'h22);
      step("match_x7", 1'b1, 5'd7, 4'd9, 32'h33, 1'b0, 5'd0, 4'd0, 1'b0, 5'd7, 5'd0);
      probe("x7_final", 5'd7, 1'b0, '0, 32'h33);

      step("ren_x4", 1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd4, 4'd1, 1'b0, 5'd4, 5'd0);
      step("cr_x4", 1'b1, 5'd4, 4'd1, 32'h44, 1'b1, 5'd4, 4'd6, 1'b0, 5'd4, 5'd0);
      probe("x4_renamed", 5'd4, 1'b1, 4'd6, 32'h44);

      for (int i = 1; i < 32; i++)
         step("ren_all", 1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'(i), 4'(i), 1'b0, 5'(i), 5'(i - 1));
      step("flush", 1'b1, 5'd3, 4'd0, 32'h55, 1'b1, 5'd9, 4'd5, 1'b1, 5'd3, 5'd9);
      for (int i = 0; i < 32; i++)
         step("post_flush", 1'b0, 5'd0, 4'd0, 32'h0, 1'b0, 5'd0, 4'd0, 1'b0, 5'(i), 5'd3);
      probe("x3_flush", 5'd3, 1'b0, '0, 32'h55);
      probe("x9_flush", 5'd9, 1'b0, '0, 32'h0);

      step("x0_write", 1'b1, 5'd0, 4'd0, 32'hFFFF, 1'b1, 5'd0, 4'd7, 1'b0, 5'd0, 5'd0);
      probe("x0", 5'd0, 1'b0, '0, 32'h0);

      step("ren_x8", 1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd8, 4'd4, 1'b0, 5'd8, 5'd0);
      rdy = 1'b0;
      step("rdy_low", 1'b1, 5'd8, 4'd4, 32'h77, 1'b0, 5'd0, 4'd0, 1'b0, 5'd8, 5'd8);
      rdy = 1'b1;
      probe("x8_held", 5'd8, 1'b1, 4'd4, 32'h0);

      // Asynchronous reset asserted between clock edges.
      #3 rst = 1'b0;
      #1;
      model_reset();
      probe("arst_x5", 5'd5, 1'b0, '0, 32'h0);
      probe("arst_x8", 5'd8, 1'b0, '0, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int n = 0; n < 400; n++) begin
         logic [4:0] ci, q1, q2;
         logic [ROB_LOG-1:0] cid;
         ci  = 5'($urandom_range(0, 7));
         cid = ($urandom_range(0, 1) == 1) ? m_tag[ci] : ROB_LOG'($urandom);
         q1  = ($urandom_range(0, 1) == 1) ? ci : 5'($urandom_range(0, 7));
         q2  = 5'($urandom_range(0, 7));
         rdy = ($urandom_range(0, 9) != 0);
         step("rand", 1'($urandom), ci, cid, $urandom, 1'($urandom), 5'($urandom_range(0, 7)),
              ROB_LOG'($urandom), ($urandom_range(0, 19) == 0), q1, q2);
      end
      rdy = 1'b1;
      for (int i = 0; i < 8; i++)
         step("final", 1'b0, 5'd0, 4'd0, 32'h0, 1'b0, 5'd0, 4'd0, 1'b0, 5'(i), 5'(7 - i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
